// File: rtl/token_share_scheduler.sv
// token_share_scheduler: round-robin arbiter sharing one serial token slot among N streams,
// passing 1 of every R[c] granted tokens per channel and absorbing the rest.
module token_share_scheduler #(
    parameter int N  = 4,
    parameter int CW = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_ch,
    input  logic [CW-1:0] cfg_ratio,
    output logic          out_valid,
    output logic [IW-1:0] out_ch,
    output logic          absorb_pulse
);
    logic [IW-1:0] r_ptr;
    logic [CW-1:0] r_ratio [N];
    logic [CW-1:0] r_phase [N];
    logic          w_hit;
    logic [IW-1:0] w_g;
    logic [IW-1:0] w_idx;
    logic [CW-1:0] w_e;
    logic          w_pass;
    logic          w_cfg;

    always_comb begin
        w_hit = 1'b0;
        w_g   = '0;
        w_idx = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = IW'((int'(r_ptr) + k) % N);
            if (!w_hit && req[w_idx]) begin
                w_hit = 1'b1;
                w_g   = w_idx;
            end
        end
        w_hit  = w_hit & ~rst;
        gnt    = w_hit ? N'(1) << w_g : '0;
        // ratios 0 and 1 both mean pass every token
        w_e    = (r_ratio[w_g] == '0) ? CW'(1) : r_ratio[w_g];
        w_pass = r_phase[w_g] == w_e - CW'(1);
        w_cfg  = cfg_we && (32'(cfg_ch) < N);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= '0;
            out_valid    <= 1'b0;
            out_ch       <= '0;
            absorb_pulse <= 1'b0;
            for (int c = 0; c < N; c++) begin
                r_ratio[c] <= CW'(2);
                r_phase[c] <= '0;
            end
        end else begin
            out_valid    <= w_hit && w_pass;
            absorb_pulse <= w_hit && !w_pass;
            if (w_hit && w_pass) out_ch <= w_g;
            if (w_hit) begin
                r_ptr      <= (w_g == IW'(N - 1)) ? '0 : w_g + 1'b1;
                r_phase[w_g] <= w_pass ? '0 : r_phase[w_g] + CW'(1);
            end
            // a same-cycle config write overrides the phase advance above
            if (w_cfg) begin
                r_ratio[cfg_ch] <= cfg_ratio;
                r_phase[cfg_ch] <= '0;
            end
        end
    end
endmodule

// File: tb/tb_token_share_scheduler.sv
// tb_token_share_scheduler: directed and randomized checks against a behavioural
// round-robin / keep-ratio model.
module tb_token_share_scheduler;
    logic       clk = 0;
    logic       rst = 1;
    logic [3:0] req = 0;
    logic [3:0] gnt;
    logic       cfg_we = 0;
    logic [1:0] cfg_ch = 0;
    logic [3:0] cfg_ratio = 0;
    logic       out_valid;
    logic [1:0] out_ch;
    logic       absorb_pulse;

    int errors = 0;
    int checks = 0;

    int mR [4];
    int mP [4];
    int mptr;
    logic [3:0] e_gnt, o_gnt;
    logic       m_v, m_ab, o_v, o_ab;
    logic [1:0] m_ch, o_ch;

    token_share_scheduler #(.N(4), .CW(4)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_ratio(cfg_ratio),
        .out_valid(out_valid), .out_ch(out_ch), .absorb_pulse(absorb_pulse)
    );

    always #5 clk = ~clk;

    // One cycle: drive at negedge, sample gnt mid-low phase, sample outputs 1 after posedge.
    task automatic stepc(input logic [3:0] rq, input logic we, input logic [1:0] ch, input logic [3:0] ra);
        int g;
        int e;
        logic pass;
        req = rq; cfg_we = we; cfg_ch = ch; cfg_ratio = ra;
        #1;
        o_gnt = gnt;
        g = -1;
        for (int k = 0; k < 4; k++)
            if (g < 0 && rq[(mptr + k) % 4]) g = (mptr + k) % 4;
        if (rst) g = -1;
        e_gnt = (g >= 0) ? 4'(1 << g) : 4'b0;
        @(posedge clk);
        if (rst) begin
            m_v = 0; m_ab = 0; m_ch = 0; mptr = 0;
            for (int c = 0; c < 4; c++) begin mR[c] = 2; mP[c] = 0; end
        end else begin
            m_v = 0; m_ab = 0;
            if (g >= 0) begin
                e = (mR[g] < 1) ? 1 : mR[g];
                pass = (mP[g] == e - 1);
                m_v = pass; m_ab = !pass;
                if (pass) m_ch = 2'(g);
                mP[g] = pass ? 0 : mP[g] + 1;
                mptr = (g + 1) % 4;
            end
            if (we) begin mR[ch] = ra; mP[ch] = 0; end
        end
        #1;
        o_v = out_valid; o_ab = absorb_pulse; o_ch = out_ch;
        @(negedge clk);
    endtask

    task automatic step(input logic [3:0] rq);
        stepc(rq, 1'b0, 2'd0, 4'd0);
    endtask

    task automatic do_reset();
        rst = 1;
        step(4'b0000);
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        step(4'b1111);
        checks++; if (o_gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", o_gnt); end
        checks++; if ({o_v, o_ab, o_ch} !== 4'b0000) begin errors++; $display("FAIL reset_outs got v=%b ab=%b ch=%0d exp 0", o_v, o_ab, o_ch); end
        rst = 0;
    endtask

    task automatic test_single_stream();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(4'b0001);
            checks++; if (o_gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt[%0d] got=%b exp=0001", i, o_gnt); end
            checks++; if (o_v !== 1'(i % 2) || o_ab !== 1'((i + 1) % 2)) begin errors++; $display("FAIL single_out[%0d] got v=%b ab=%b exp v=%0d", i, o_v, o_ab, i % 2); end
            checks++; if (o_v && o_ch !== 2'd0) begin errors++; $display("FAIL single_ch[%0d] got=%0d exp=0", i, o_ch); end
        end
    endtask

    task automatic test_rotation();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(4'b1111);
            checks++; if (o_gnt !== 4'(1 << (i % 4))) begin errors++; $display("FAIL rot_gnt[%0d] got=%b exp=%b", i, o_gnt, 4'(1 << (i % 4))); end
            checks++; if (o_v !== (i >= 4) || o_ab !== (i < 4)) begin errors++; $display("FAIL rot_out[%0d] got v=%b ab=%b", i, o_v, o_ab); end
            checks++; if (o_v && o_ch !== 2'(i % 4)) begin errors++; $display("FAIL rot_ch[%0d] got=%0d exp=%0d", i, o_ch, i % 4); end
        end
    endtask

    task automatic test_ratio3();
        logic [5:0] pat;
        pat = 6'b100100;
        do_reset();
        stepc(4'b0000, 1'b1, 2'd1, 4'd3);
        for (int i = 0; i < 6; i++) begin
            step(4'b0010);
            checks++; if (o_v !== pat[i] || o_ab === pat[i]) begin errors++; $display("FAIL ratio3[%0d] got v=%b ab=%b exp v=%b", i, o_v, o_ab, pat[i]); end
            checks++; if (o_v && o_ch !== 2'd1) begin errors++; $display("FAIL ratio3_ch[%0d] got=%0d exp=1", i, o_ch); end
        end
        stepc(4'b0000, 1'b1, 2'd1, 4'd0);
        for (int i = 0; i < 3; i++) begin
            step(4'b0010);
            checks++; if (o_v !== 1'b1 || o_ab !== 1'b0) begin errors++; $display("FAIL ratio0[%0d] got v=%b ab=%b exp v=1", i, o_v, o_ab); end
        end
    endtask

    task automatic test_alternate_idle();
        logic [3:0] exp_g;
        do_reset();
        step(4'b0001);
        for (int i = 0; i < 4; i++) begin
            step(4'b0101);
            exp_g = (i % 2 == 0) ? 4'b0100 : 4'b0001;
            checks++; if (o_gnt !== exp_g) begin errors++; $display("FAIL alt_gnt[%0d] got=%b exp=%b", i, o_gnt, exp_g); end
        end
        for (int i = 0; i < 2; i++) begin
            step(4'b0000);
            checks++; if (o_gnt !== 4'b0 || o_v !== 1'b0 || o_ab !== 1'b0) begin errors++; $display("FAIL idle[%0d] got gnt=%b v=%b ab=%b exp 0", i, o_gnt, o_v, o_ab); end
        end
        step(4'b0101);
        checks++; if (o_gnt !== 4'b0100) begin errors++; $display("FAIL idle_ptr got=%b exp=0100", o_gnt); end
    endtask

    task automatic test_cfg_collision();
        logic [3:0] pat;
        pat = 4'b1000;
        do_reset();
        step(4'b0001);
        stepc(4'b0001, 1'b1, 2'd0, 4'd4);
        checks++; if (o_v !== 1'b1 || o_ab !== 1'b0) begin errors++; $display("FAIL collide_pass got v=%b ab=%b exp v=1", o_v, o_ab); end
        for (int i = 0; i < 4; i++) begin
            step(4'b0001);
            checks++; if (o_v !== pat[i] || o_ab === pat[i]) begin errors++; $display("FAIL collide[%0d] got v=%b ab=%b exp v=%b", i, o_v, o_ab, pat[i]); end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        step(4'b1111);
        step(4'b1111);
        rst = 1;
        step(4'b1111);
        checks++; if (o_gnt !== 4'b0) begin errors++; $display("FAIL midrst_gnt got=%b exp=0000", o_gnt); end
        checks++; if (o_v !== 1'b0 || o_ab !== 1'b0 || o_ch !== 2'd0) begin errors++; $display("FAIL midrst_out got v=%b ab=%b ch=%0d exp 0", o_v, o_ab, o_ch); end
        rst = 0;
        step(4'b1111);
        checks++; if (o_gnt !== 4'b0001 || o_ab !== 1'b1) begin errors++; $display("FAIL midrst_restart got gnt=%b ab=%b exp 0001/1", o_gnt, o_ab); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0)
                stepc(4'($urandom_range(0, 15)), 1'b1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 5)));
            else
                step(4'($urandom_range(0, 15)));
            checks++; if (o_gnt !== e_gnt) begin errors++; $display("FAIL rand_gnt[%0d] got=%b exp=%b", i, o_gnt, e_gnt); end
            checks++; if (o_v !== m_v || o_ab !== m_ab || (m_v && o_ch !== m_ch)) begin
                errors++; $display("FAIL rand_out[%0d] got v=%b ab=%b ch=%0d exp v=%b ab=%b ch=%0d", i, o_v, o_ab, o_ch, m_v, m_ab, m_ch);
            end
        end
    endtask

    initial begin
        mptr = 0;
        @(negedge clk);
        test_reset();
        test_single_stream();
        test_rotation();
        test_ratio3();
        test_alternate_idle();
        test_cfg_collision();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
